// File: rtl/ws_pixel_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : ws_pixel_serializer
//  Description : Accepts whole pixel words over a valid/ready handshake and
//                serialises them MSB-first as WS281x NRZ waveforms. Bit
//                counting, bit timing and the reset/latch (RET) low period
//                are handled here. The strip controller supplies pixels and
//                a frame-end strobe.
//  Ports       : clk          system clock
//                reset        synchronous, active-high reset
//                pixel_data   pixel word, MSB transmitted first
//                pixel_valid  pixel_data is valid
//                pixel_ready  pixel accepted this cycle when valid & ready
//                frame_end    one-cycle strobe: latch after current/last pixel
//                dout         serial line to the LED strip (registered)
//                busy         high while sending or latching
//                ret_done     one-cycle pulse on the final RET cycle
//  Options     : WS_OUT_INVERT_EN - invert dout at the output register for
//                an inverting level-shifter stage (idle/RET level becomes 1).
//  Revision    : 1.0 - initial release
// ============================================================================
module ws_pixel_serializer #(
    parameter int BIT_CYCLES = 125,
    parameter int T0H_CYCLES = 40,
    parameter int T1H_CYCLES = 80,
    parameter int PIXEL_BITS = 24,
    parameter int RET_CYCLES = 6000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [PIXEL_BITS-1:0] pixel_data,
    input  logic                  pixel_valid,
    output logic                  pixel_ready,
    input  logic                  frame_end,
    output logic                  dout,
    output logic                  busy,
    output logic                  ret_done
);

    localparam int c_CYC_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int c_BIT_W = (PIXEL_BITS > 1) ? $clog2(PIXEL_BITS) : 1;
    localparam int c_RET_W = (RET_CYCLES > 1) ? $clog2(RET_CYCLES) : 1;

    localparam logic [c_CYC_W-1:0] c_CYC_LAST = c_CYC_W'(BIT_CYCLES - 1);
    localparam logic [c_CYC_W-1:0] c_CYC_ONE  = c_CYC_W'(1);
    localparam logic [c_CYC_W-1:0] c_T0H      = c_CYC_W'(T0H_CYCLES);
    localparam logic [c_CYC_W-1:0] c_T1H      = c_CYC_W'(T1H_CYCLES);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(PIXEL_BITS - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_ONE  = c_BIT_W'(1);
    localparam logic [c_RET_W-1:0] c_RET_LAST = c_RET_W'(RET_CYCLES - 1);
    localparam logic [c_RET_W-1:0] c_RET_ONE  = c_RET_W'(1);

    // Line level when not actively sending (and the reset level of dout).
`ifdef WS_OUT_INVERT_EN
    localparam logic c_IDLE_LEVEL = 1'b1;
`else
    localparam logic c_IDLE_LEVEL = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Elaboration-time parameter sanity checks
    // ------------------------------------------------------------------
    if (!(T0H_CYCLES > 0 && T0H_CYCLES < T1H_CYCLES && T1H_CYCLES < BIT_CYCLES))
    begin : g_chk_timing
        $error("ws_pixel_serializer: need 0 < T0H_CYCLES < T1H_CYCLES < BIT_CYCLES");
    end
    if (PIXEL_BITS < 1) begin : g_chk_pixel_bits
        $error("ws_pixel_serializer: PIXEL_BITS must be >= 1");
    end
    if (RET_CYCLES < 1) begin : g_chk_ret_cycles
        $error("ws_pixel_serializer: RET_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_RET  = 2'd2
    } state_t;

    state_t                r_state,        w_stateNext;
    logic [c_CYC_W-1:0]    r_cyc,          w_cycNext;
    logic [c_BIT_W-1:0]    r_bitIdx,       w_bitIdxNext;
    logic [c_RET_W-1:0]    r_retCnt,       w_retCntNext;
    logic [PIXEL_BITS-1:0] r_shift,        w_shiftNext;
    logic                  r_latchPending, w_latchPendingNext;
    logic                  r_dout,         w_doutNext;

    logic w_endBit;
    logic w_endPixel;
    logic w_accept;
    logic w_sendLevel;

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_stateNext        = r_state;
        w_cycNext          = r_cyc;
        w_bitIdxNext       = r_bitIdx;
        w_retCntNext       = r_retCnt;
        w_shiftNext        = r_shift;
        w_latchPendingNext = r_latchPending;

        w_endBit   = (r_cyc == c_CYC_LAST);
        w_endPixel = w_endBit && (r_bitIdx == c_BIT_LAST);

        // Ready opens in IDLE, and in SEND only on the last cycle of a pixel
        // when no latch is queued, which gives gap-free back-to-back pixels.
        pixel_ready = (r_state == S_IDLE) ||
                      ((r_state == S_SEND) && w_endPixel && !r_latchPending);
        busy        = (r_state != S_IDLE);
        ret_done    = (r_state == S_RET) && (r_retCnt == c_RET_LAST);
        w_accept    = pixel_valid && pixel_ready;

        // A latch request is remembered until RET is entered; requests that
        // arrive during RET are dropped so a strobe never latches twice.
        if (frame_end && (r_state != S_RET)) begin
            w_latchPendingNext = 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_stateNext  = S_SEND;
                    w_shiftNext  = pixel_data;
                    w_cycNext    = '0;
                    w_bitIdxNext = '0;
                end else if (frame_end || r_latchPending) begin
                    w_stateNext        = S_RET;
                    w_retCntNext       = '0;
                    w_latchPendingNext = 1'b0;
                end
            end

            S_SEND: begin
                if (w_endPixel) begin
                    w_cycNext    = '0;
                    w_bitIdxNext = '0;
                    if (w_accept) begin
                        // Next pixel follows immediately; a simultaneous
                        // frame_end stays pending until that pixel is out.
                        w_shiftNext = pixel_data;
                    end else if (r_latchPending || frame_end) begin
                        w_stateNext        = S_RET;
                        w_retCntNext       = '0;
                        w_latchPendingNext = 1'b0;
                    end else begin
                        w_stateNext = S_IDLE;
                    end
                end else if (w_endBit) begin
                    w_cycNext    = '0;
                    w_bitIdxNext = r_bitIdx + c_BIT_ONE;
                    w_shiftNext  = r_shift << 1;
                end else begin
                    w_cycNext = r_cyc + c_CYC_ONE;
                end
            end

            S_RET: begin
                if (r_retCnt == c_RET_LAST) begin
                    w_stateNext  = S_IDLE;
                    w_retCntNext = '0;
                end else begin
                    w_retCntNext = r_retCnt + c_RET_ONE;
                end
            end

            default: begin
                w_stateNext = S_IDLE;
            end
        endcase

        // dout is registered from the next-state values so the line level
        // lines up with the state it belongs to, with no input-to-pin path.
        w_sendLevel = (w_stateNext == S_SEND) &&
                      (w_cycNext < (w_shiftNext[PIXEL_BITS-1] ? c_T1H : c_T0H));
        w_doutNext  = w_sendLevel ^ c_IDLE_LEVEL;
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_cyc          <= '0;
            r_bitIdx       <= '0;
            r_retCnt       <= '0;
            r_shift        <= '0;
            r_latchPending <= 1'b0;
            r_dout         <= c_IDLE_LEVEL;
        end else begin
            r_state        <= w_stateNext;
            r_cyc          <= w_cycNext;
            r_bitIdx       <= w_bitIdxNext;
            r_retCnt       <= w_retCntNext;
            r_shift        <= w_shiftNext;
            r_latchPending <= w_latchPendingNext;
            r_dout         <= w_doutNext;
        end
    end

    assign dout = r_dout;

endmodule
`default_nettype wire

// File: tb/tb_ws_pixel_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ws_pixel_serializer
//  Description : Directed self-checking bench for ws_pixel_serializer. DUT A
//                uses default timing (24-bit GRB); DUT B uses the 32-bit
//                reduced-timing parameter set.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ws_pixel_serializer;

`ifdef WS_OUT_INVERT_EN
    localparam logic c_INV = 1'b1;
`else
    localparam logic c_INV = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    logic [23:0] dataA;
    logic        validA, feA;
    logic        readyA, doutA, busyA, retDoneA;

    logic [31:0] dataB;
    logic        validB, feB;
    logic        readyB, doutB, busyB, retDoneB;

    always #5 clk = ~clk;

    ws_pixel_serializer u_dutA (
        .clk         (clk),
        .reset       (reset),
        .pixel_data  (dataA),
        .pixel_valid (validA),
        .pixel_ready (readyA),
        .frame_end   (feA),
        .dout        (doutA),
        .busy        (busyA),
        .ret_done    (retDoneA)
    );

    ws_pixel_serializer #(
        .BIT_CYCLES (60),
        .T0H_CYCLES (18),
        .T1H_CYCLES (36),
        .PIXEL_BITS (32),
        .RET_CYCLES (300)
    ) u_dutB (
        .clk         (clk),
        .reset       (reset),
        .pixel_data  (dataB),
        .pixel_valid (validB),
        .pixel_ready (readyB),
        .frame_end   (feB),
        .dout        (doutB),
        .busy        (busyB),
        .ret_done    (retDoneB)
    );

    int nChecks = 0;
    int nPassed = 0;

    int highs [32];
    int shapeBad, readyCnt, readyLast;
    int retLen, retDoneAt, retDoneCnt, retHigh, retReady;

    task automatic chk(input string tag, input int got, input int exp);
        nChecks++;
        if (got == exp) nPassed++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic level(input bit useB);
        return (useB ? doutB : doutA) ^ c_INV;
    endfunction

    // Walk one whole pixel period, recording high time per bit and ready.
    task automatic run_pixel(input bit useB, input int nBits, input int bitCyc, input int feAt);
        int b, c;
        for (int i = 0; i < 32; i++) highs[i] = 0;
        shapeBad = 0; readyCnt = 0; readyLast = -1;
        for (int k = 0; k < nBits * bitCyc; k++) begin
            if (useB) feB = (k == feAt); else feA = (k == feAt);
            b = k / bitCyc;
            c = k % bitCyc;
            if (level(useB)) begin
                if (c != highs[b]) shapeBad++;
                highs[b]++;
            end
            if (useB ? readyB : readyA) begin
                readyCnt++;
                readyLast = k;
            end
            if (!(useB ? busyB : busyA)) shapeBad++;
            tick();
        end
        feA = 1'b0;
        feB = 1'b0;
    endtask

    // Count the latch period, bounded so a stuck DUT cannot hang the run.
    task automatic run_ret(input bit useB, input int maxCyc);
        retLen = 0; retDoneAt = -1; retDoneCnt = 0; retHigh = 0; retReady = 0;
        while ((useB ? busyB : busyA) && retLen < maxCyc) begin
            if (level(useB)) retHigh++;
            if (useB ? readyB : readyA) retReady++;
            if (useB ? retDoneB : retDoneA) begin
                retDoneAt = retLen;
                retDoneCnt++;
            end
            retLen++;
            tick();
        end
    endtask

    task automatic check_pixel(input string tag, input logic [31:0] word,
                               input int nBits, input int t0, input int t1);
        int bad = 0;
        for (int b = 0; b < nBits; b++)
            if (highs[b] != (word[nBits-1-b] ? t1 : t0)) bad++;
        chk({tag, " bad bits"}, bad, 0);
        chk({tag, " shape"}, shapeBad, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        dataA = '0; validA = 1'b0; feA = 1'b0;
        dataB = '0; validB = 1'b0; feB = 1'b0;
        tick(); tick(); tick();

        // Reset state
        chk("rst doutA", int'(doutA), int'(c_INV));
        chk("rst readyA", int'(readyA), 1);
        chk("rst busyA", int'(busyA), 0);
        chk("rst retDoneA", int'(retDoneA), 0);
        chk("rst doutB", int'(doutB), int'(c_INV));
        reset = 1'b0;
        tick();
        chk("idle busyA", int'(busyA), 0);

        // Single pixel A50000 then frame_end
        dataA = 24'hA50000; validA = 1'b1;
        tick();
        validA = 1'b0;
        chk("s1 first dout", int'(level(1'b0)), 1);
        run_pixel(1'b0, 24, 125, 0);
        chk("s1 bit0 high", highs[0], 80);
        chk("s1 bit1 high", highs[1], 40);
        check_pixel("s1", 32'hA50000, 24, 40, 80);
        chk("s1 ready in send", readyCnt, 0);
        run_ret(1'b0, 7000);
        chk("s1 ret len", retLen, 6000);
        chk("s1 ret done at", retDoneAt, 5999);
        chk("s1 ret done cnt", retDoneCnt, 1);
        chk("s1 ret high", retHigh, 0);
        chk("s1 idle ready", int'(readyA), 1);

        // Back-to-back FFFFFF then 000000
        dataA = 24'hFFFFFF; validA = 1'b1;
        tick();
        dataA = 24'h000000;
        run_pixel(1'b0, 24, 125, -1);
        check_pixel("b2b px1", 32'hFFFFFF, 24, 40, 80);
        chk("b2b ready cnt", readyCnt, 1);
        chk("b2b ready at", readyLast, 2999);
        validA = 1'b0;
        run_pixel(1'b0, 24, 125, -1);
        chk("b2b px2 bit0 high", highs[0], 40);
        check_pixel("b2b px2", 32'h000000, 24, 40, 80);
        chk("b2b end busy", int'(busyA), 0);
        chk("b2b end ready", int'(readyA), 1);

        // frame_end mid-pixel with pixel_valid held high
        dataA = 24'h0F0F0F; validA = 1'b1;
        tick();
        run_pixel(1'b0, 24, 125, 100);
        check_pixel("fe px", 32'h0F0F0F, 24, 40, 80);
        chk("fe ready in send", readyCnt, 0);
        run_ret(1'b0, 7000);
        chk("fe ret len", retLen, 6000);
        chk("fe ret ready", retReady, 0);
        chk("fe idle ready", int'(readyA), 1);
        tick();
        chk("fe reaccept busy", int'(busyA), 1);
        validA = 1'b0;

        // Reset at SEND cycle 500 (bit 4 of 0F0F0F is a 1 -> line high)
        for (int k = 0; k < 500; k++) tick();
        chk("rs pre dout", int'(level(1'b0)), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rs dout", int'(level(1'b0)), 0);
        chk("rs busy", int'(busyA), 0);
        chk("rs ready", int'(readyA), 1);
        dataA = 24'h800001; validA = 1'b1;
        tick();
        validA = 1'b0;
        run_pixel(1'b0, 24, 125, -1);
        chk("rs bit0 high", highs[0], 80);
        chk("rs bit23 high", highs[23], 80);
        check_pixel("rs px", 32'h800001, 24, 40, 80);
        chk("rs end busy", int'(busyA), 0);

        // Parameter sweep on DUT B
        dataB = 32'h80000001; validB = 1'b1;
        tick();
        validB = 1'b0;
        run_pixel(1'b1, 32, 60, 0);
        chk("sw bit0 high", highs[0], 36);
        chk("sw bit1 high", highs[1], 18);
        chk("sw bit31 high", highs[31], 36);
        check_pixel("sw px", 32'h80000001, 32, 18, 36);
        run_ret(1'b1, 1000);
        chk("sw ret len", retLen, 300);
        chk("sw ret done at", retDoneAt, 299);
        chk("sw ret high", retHigh, 0);

        $display("%0d/%0d checks passed", nPassed, nChecks);
        $finish;
    end

endmodule
`default_nettype wire
